// File: rtl/memory_stage.sv
// memory_stage: MEM stage of the 5-stage pipeline.
// Drives the data-cache request handshake, raises mem_stall while a request
// is outstanding, and holds the MEM/WB pipeline register feeding writeback.
// Optional feature: define ATOMIC_LLSC_EN to add the LL/SC link register.
// Without it, m_datomic and the coherence inputs are ignored.
module memory_stage #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              m_dREN,
  input  logic              m_dWEN,
  input  logic              m_datomic,
  input  logic              m_RegWrite,
  input  logic              m_halt,
  input  logic [1:0]        m_MemToReg,
  input  logic [REG_W-1:0]  m_regWSEL,
  input  logic [WORD_W-1:0] m_port_o,
  input  logic [WORD_W-1:0] m_memstore,
  input  logic [WORD_W-1:0] m_pc4,
  input  logic [WORD_W-1:0] m_lui,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  input  logic              ccinv,
  input  logic [WORD_W-1:0] ccsnoopaddr,
  input  logic              wb_stall,
  input  logic              wb_flush,
  output logic              mem_stall,
  output logic              w_RegWrite,
  output logic [REG_W-1:0]  w_regWSEL,
  output logic [WORD_W-1:0] w_wdat,
  output logic              w_halt
);

  typedef enum logic [1:0] {IDLE, WAIT, HELD} state_t;

  state_t            state;
  logic [WORD_W-1:0] load_buf;
  logic              sc_fail;
  logic              memop;
  logic              req;
  logic [WORD_W-1:0] load_src;
  logic [WORD_W-1:0] wb_data;

`ifdef ATOMIC_LLSC_EN
  logic              link_valid;
  logic [WORD_W-1:0] link_addr;
  logic              sc_op;
  logic              ll_op;
  logic              sc_ok;
  logic              snoop_hit;
  logic              capture;

  assign snoop_hit = ccinv & (ccsnoopaddr == link_addr);
  assign sc_op     = m_dWEN & m_datomic;
  assign ll_op     = m_dREN & m_datomic;
  // A snoop on the linked line in the same cycle as the SC makes it fail.
  assign sc_ok     = link_valid & (link_addr == m_port_o) & ~snoop_hit;
  assign sc_fail   = sc_op & ~sc_ok;
  assign capture   = ~wb_flush & ~wb_stall & ~mem_stall;

  // Link register: set by a completed LL, cleared by snoops, SC retirement
  // and ordinary stores that hit the linked address.
  always_ff @(posedge CLK) begin
    if (RST) begin
      link_valid <= 1'b0;
      link_addr  <= '0;
    end else begin
      if (snoop_hit | (sc_op & capture) |
          (m_dWEN & ~m_datomic & req & dhit & (m_port_o == link_addr)))
        link_valid <= 1'b0;
      if (ll_op & req & dhit) begin
        link_valid <= 1'b1;
        link_addr  <= m_port_o;
      end
    end
  end
`else
  logic unused_atomic;
  assign unused_atomic = &{1'b0, m_datomic, ccinv, ccsnoopaddr};
  assign sc_fail       = 1'b0;
`endif

  // A failed SC never reaches the cache; HELD means the data is already parked.
  assign memop     = (m_dREN | m_dWEN) & ~sc_fail;
  assign req       = memop & (state != HELD) & ~wb_flush;
  assign dmemREN   = req & m_dREN;
  assign dmemWEN   = req & m_dWEN;
  assign dmemaddr  = m_port_o;
  assign dmemstore = m_memstore;
  assign mem_stall = req & ~dhit;

  // Request tracking: wait for dhit, park hit data while MEM/WB is held.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      load_buf <= '0;
    end else if (wb_flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE, WAIT: begin
          if (req & ~dhit) begin
            state <= WAIT;
          end else if (req & dhit & wb_stall) begin
            state    <= HELD;
            load_buf <= dmemload;
          end else begin
            state <= IDLE;
          end
        end
        HELD:    if (~wb_stall) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Writeback data select; parked load data replaces dmemload once HELD.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    load_src = dmemload;
    wb_data  = m_port_o;
    if (state == HELD) load_src = load_buf;
    case (m_MemToReg)
      2'b00:   wb_data = m_port_o;
      2'b01:   wb_data = load_src;
      2'b10:   wb_data = m_pc4;
      default: wb_data = m_lui;
    endcase
`ifdef ATOMIC_LLSC_EN
    // SC returns its success flag; reaching HELD means the store was issued.
    if (sc_op) wb_data = {{(WORD_W-1){1'b0}}, sc_ok | (state == HELD)};
`endif
  end

  // MEM/WB register: reset > flush > hold > bubble > capture; halt is sticky.
  always_ff @(posedge CLK) begin
    if (RST) begin
      w_RegWrite <= 1'b0;
      w_regWSEL  <= '0;
      w_wdat     <= '0;
      w_halt     <= 1'b0;
    end else if (wb_flush) begin
      w_RegWrite <= 1'b0;
      w_regWSEL  <= '0;
      w_wdat     <= '0;
    end else if (wb_stall) begin
      w_RegWrite <= w_RegWrite;
    end else if (mem_stall) begin
      w_RegWrite <= 1'b0;
    end else begin
      w_RegWrite <= m_RegWrite;
      w_regWSEL  <= m_regWSEL;
      w_wdat     <= wb_data;
      w_halt     <= w_halt | m_halt;
    end
  end

endmodule
